// File: rtl/rf_bypass_pkg.sv
// Shared register-file types and default geometry for the bypassed register file
// and its reservation scoreboard.
package rf_bypass_pkg;

  localparam int REG_AMT     = 16;
  localparam int READ_PORTS  = 2;
  localparam int WRITE_PORTS = 2;
  localparam int DATA_WIDTH  = 32;
  localparam int RF_ADRS_W   = $clog2(REG_AMT);

  typedef logic [DATA_WIDTH-1:0] t_data;
  typedef logic [RF_ADRS_W-1:0]  t_RFadrs;

endpackage

// File: rtl/rf_bypass_if.sv
// Read, write and reservation signal bundle between a pipeline (master) and the
// register file (slave).
interface rf_bypass_if
  import rf_bypass_pkg::*;
#(
  parameter int NUM_READ  = rf_bypass_pkg::READ_PORTS,
  parameter int NUM_WRITE = rf_bypass_pkg::WRITE_PORTS,
  parameter int REG_AMT   = rf_bypass_pkg::REG_AMT,
  parameter int DATA_W    = $bits(t_data),
  parameter int AW        = $clog2(REG_AMT)
) ();

  logic [NUM_READ-1:0][AW-1:0]      src;
  logic [NUM_READ-1:0][DATA_W-1:0]  dataout;
  logic [NUM_READ-1:0]              rd_busy;
  logic [NUM_WRITE-1:0][AW-1:0]     dst;
  logic [NUM_WRITE-1:0][DATA_W-1:0] datain;
  logic [NUM_WRITE-1:0]             wr_en;
  logic                             rsv_en;
  logic [AW-1:0]                    rsv_adrs;
  logic [REG_AMT-1:0]               busy;

  modport master (
    output src, dst, datain, wr_en, rsv_en, rsv_adrs,
    input  dataout, rd_busy, busy
  );

  modport slave (
    input  src, dst, datain, wr_en, rsv_en, rsv_adrs,
    output dataout, rd_busy, busy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bit: set by a reservation, cleared by a write; a
// reservation in the same cycle as a write to that register keeps it pending.
module rf_scoreboard
  import rf_bypass_pkg::*;
#(
  parameter int NUM_WRITE = rf_bypass_pkg::WRITE_PORTS,
  parameter int REG_AMT   = rf_bypass_pkg::REG_AMT,
  parameter int ZERO_REG  = 1,
  parameter int AW        = $clog2(REG_AMT)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_WRITE-1:0][AW-1:0] dst,
  input  logic [NUM_WRITE-1:0]         wr_en,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_adrs,
  output logic [REG_AMT-1:0]           busy
);

  logic [REG_AMT-1:0] busy_d, busy_q;

  function automatic logic adrs_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(REG_AMT)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // NOTE: combinational blocks use blocking '=' and start from a full default, so
  // later loop iterations see earlier updates and no latch can be inferred.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j] && adrs_ok(dst[j])) busy_d[dst[j]] = 1'b0;
    end
    // Applied after the clears so a fresh reservation wins over a completing write.
    if (rsv_en && adrs_ok(rsv_adrs)) busy_d[rsv_adrs] = 1'b1;
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/rf_bypass.sv
// Multi-ported register file with same-cycle write-to-read bypass and a
// reservation scoreboard reporting which read operands are still pending.
module rf_bypass
  import rf_bypass_pkg::*;
#(
  parameter int NUM_READ  = rf_bypass_pkg::READ_PORTS,
  parameter int NUM_WRITE = rf_bypass_pkg::WRITE_PORTS,
  parameter int REG_AMT   = rf_bypass_pkg::REG_AMT,
  parameter int DATA_W    = $bits(t_data),
  parameter int ZERO_REG  = 1
) (
  input logic        clock,
  input logic        reset,
  rf_bypass_if.slave bus
);

  localparam int AW = $clog2(REG_AMT);

  logic [DATA_W-1:0]  regs_d [REG_AMT];
  logic [DATA_W-1:0]  regs_q [REG_AMT];
  logic [REG_AMT-1:0] busy;

  function automatic logic adrs_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(REG_AMT)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  rf_scoreboard #(
    .NUM_WRITE (NUM_WRITE),
    .REG_AMT   (REG_AMT),
    .ZERO_REG  (ZERO_REG),
    .AW        (AW)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .dst      (bus.dst),
    .wr_en    (bus.wr_en),
    .rsv_en   (bus.rsv_en),
    .rsv_adrs (bus.rsv_adrs),
    .busy     (busy)
  );

  assign bus.busy = busy;

  // Ascending port order makes the highest-indexed writer the last one applied.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (bus.wr_en[j] && adrs_ok(bus.dst[j])) regs_d[bus.dst[j]] = bus.datain[j];
    end
  end

  // NOTE: the whole array is cleared on reset because architectural state must
  // read as zero afterwards; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // The bypass ignores reset: a write presented during reset is still forwarded.
  always_comb begin
    logic [DATA_W-1:0] rd_data;
    logic              wr_hit;
    logic              rsv_hit;
    bus.dataout = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_data = '0;
      wr_hit  = 1'b0;
      rsv_hit = 1'b0;
      if (adrs_ok(bus.src[i])) begin
        rd_data = regs_q[bus.src[i]];
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (bus.wr_en[j] && (bus.dst[j] == bus.src[i])) begin
            rd_data = bus.datain[j];
            wr_hit  = 1'b1;
          end
        end
        rsv_hit = bus.rsv_en && (bus.rsv_adrs == bus.src[i]);
        bus.rd_busy[i] = busy[bus.src[i]] && !(wr_hit && !rsv_hit);
      end
      bus.dataout[i] = rd_data;
    end
  end

endmodule

// File: tb/tb_rf_bypass.sv
// Self-checking bench for rf_bypass: a reference model predicts every cycle's
// outputs into a queue that is drained and compared mid-cycle.
module tb_rf_bypass;
  import rf_bypass_pkg::*;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int RA = 16;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rf_bypass_if #(.NUM_READ(NR), .NUM_WRITE(NW), .REG_AMT(RA), .DATA_W(DW)) bus ();

  rf_bypass #(
    .NUM_READ  (NR),
    .NUM_WRITE (NW),
    .REG_AMT   (RA),
    .DATA_W    (DW),
    .ZERO_REG  (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NR-1:0][DW-1:0] data;
    logic [NR-1:0]         rbusy;
    logic [RA-1:0]         busy;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_regs [RA];
  logic [RA-1:0] m_busy;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for the inputs currently driven and the model's stored state.
  function automatic exp_t predict();
    exp_t e;
    e.busy = m_busy;
    for (int i = 0; i < NR; i++) begin
      logic [DW-1:0] d;
      logic          hit;
      logic          rsv;
      d = 0; hit = 0; rsv = 0;
      if (bus.src[i] != 0) begin
        d = m_regs[bus.src[i]];
        for (int j = 0; j < NW; j++)
          if (bus.wr_en[j] && bus.dst[j] == bus.src[i]) begin d = bus.datain[j]; hit = 1; end
        rsv = bus.rsv_en && (bus.rsv_adrs == bus.src[i]);
      end
      e.data[i]  = d;
      e.rbusy[i] = (bus.src[i] != 0) && m_busy[bus.src[i]] && !(hit && !rsv);
    end
    return e;
  endfunction

  task automatic idle();
    bus.wr_en  = '0;
    bus.rsv_en = 1'b0;
  endtask

  task automatic push_exp();
    exp_q.push_back(predict());
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clock);
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < NR; i++) begin
        check($sformatf("dataout%0d", i), 64'(bus.dataout[i]), 64'(e.data[i]));
        check($sformatf("rd_busy%0d", i), 64'(bus.rd_busy[i]), 64'(e.rbusy[i]));
      end
      check("busy_vec", 64'(bus.busy), 64'(e.busy));
    end
  endtask

  task automatic advance();
    @(posedge clock);
    if (reset) begin
      for (int k = 0; k < RA; k++) m_regs[k] = '0;
      m_busy = '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (bus.wr_en[j] && bus.dst[j] != 0) begin
          m_regs[bus.dst[j]] = bus.datain[j];
          m_busy[bus.dst[j]] = 1'b0;
        end
      if (bus.rsv_en && bus.rsv_adrs != 0) m_busy[bus.rsv_adrs] = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    push_exp();
    sample();
    advance();
  endtask

  initial begin
    for (int k = 0; k < RA; k++) m_regs[k] = '0;
    m_busy        = '0;
    reset         = 1'b1;
    bus.src       = '0;
    bus.dst       = '0;
    bus.datain    = '0;
    bus.rsv_adrs  = '0;
    idle();
    #1;
    step();
    reset = 1'b0;
    step();

    // Every register reads zero and nothing is pending after reset.
    for (int k = 0; k < RA; k++) begin
      bus.src[0] = AW'(k);
      bus.src[1] = AW'(RA - 1 - k);
      push_exp();
      sample();
      check("rst_data0", 64'(bus.dataout[0]), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      advance();
    end

    // Two ports write r3 in one cycle: the higher port wins, also on the bypass.
    bus.wr_en     = 2'b11;
    bus.dst[0]    = 4'd3; bus.datain[0] = 32'h11;
    bus.dst[1]    = 4'd3; bus.datain[1] = 32'h22;
    bus.src[0]    = 4'd3;
    push_exp(); sample();
    check("wr_conflict_bypass", 64'(bus.dataout[0]), 64'h22);
    advance();
    idle();
    push_exp(); sample();
    check("wr_conflict_stored", 64'(bus.dataout[0]), 64'h22);
    advance();

    // Register 0 is hardwired to zero.
    bus.wr_en     = 2'b01;
    bus.dst[0]    = 4'd0; bus.datain[0] = 32'hFFFF_FFFF;
    bus.src[0]    = 4'd0;
    push_exp(); sample();
    check("r0_bypass", 64'(bus.dataout[0]), 64'd0);
    advance();
    idle();
    push_exp(); sample();
    check("r0_stored", 64'(bus.dataout[0]), 64'd0);
    advance();

    // Reserve r5, observe pending, then complete it with a bypassed write.
    bus.rsv_en = 1'b1; bus.rsv_adrs = 4'd5; bus.src[0] = 4'd5;
    step();
    idle();
    push_exp(); sample();
    check("rsv_pending", 64'(bus.rd_busy[0]), 64'd1);
    advance();
    bus.wr_en = 2'b01; bus.dst[0] = 4'd5; bus.datain[0] = 32'h5A;
    push_exp(); sample();
    check("rsv_wr_busy", 64'(bus.rd_busy[0]), 64'd0);
    check("rsv_wr_data", 64'(bus.dataout[0]), 64'h5A);
    advance();
    idle();
    push_exp(); sample();
    check("rsv_cleared", 64'(bus.busy[5]), 64'd0);
    advance();

    // Reservation and write to r7 together: the reservation survives.
    bus.rsv_en = 1'b1; bus.rsv_adrs = 4'd7;
    bus.wr_en  = 2'b01; bus.dst[0] = 4'd7; bus.datain[0] = 32'h1;
    step();
    idle();
    bus.src[0] = 4'd7;
    push_exp(); sample();
    check("rsv_wins_busy", 64'(bus.busy[7]), 64'd1);
    check("rsv_wins_data", 64'(bus.dataout[0]), 64'h1);
    advance();

    // Mid-stream reset with r2 pending and holding 0x9; a write to r4 is discarded.
    bus.rsv_en = 1'b1; bus.rsv_adrs = 4'd2;
    bus.wr_en  = 2'b01; bus.dst[0] = 4'd2; bus.datain[0] = 32'h9;
    step();
    reset = 1'b1;
    bus.rsv_en = 1'b1; bus.rsv_adrs = 4'd4;
    bus.wr_en  = 2'b01; bus.dst[0] = 4'd4; bus.datain[0] = 32'h44;
    bus.src[0] = 4'd2; bus.src[1] = 4'd4;
    push_exp(); sample();
    check("rst_mid_pre", 64'(bus.busy[2]), 64'd1);
    check("rst_mid_bypass", 64'(bus.dataout[1]), 64'h44);
    advance();
    reset = 1'b0;
    idle();
    push_exp(); sample();
    check("rst_mid_r2", 64'(bus.dataout[0]), 64'd0);
    check("rst_mid_r4", 64'(bus.dataout[1]), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    advance();

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 49) == 0);
      bus.wr_en    = NW'($urandom);
      bus.rsv_en   = ($urandom_range(0, 2) == 0);
      bus.rsv_adrs = AW'($urandom_range(0, RA - 1));
      for (int j = 0; j < NW; j++) begin
        bus.dst[j]    = AW'($urandom_range(0, RA - 1));
        bus.datain[j] = $urandom;
      end
      for (int i = 0; i < NR; i++) bus.src[i] = AW'($urandom_range(0, RA - 1));
      step();
    end
    reset = 1'b0;
    idle();

    if (exp_q.size() != 0) check("queue_leftover", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_bypass.md
RF_BYPASS -- requirements
Module: rf_bypass

Interface
REQ-001 SHALL have parameter NUM_READ, default 2: number of read ports.
REQ-002 SHALL have parameter NUM_WRITE, default 2: number of write ports.
REQ-003 SHALL have parameter REG_AMT, default 16: number of architectural registers; address width is clog2(REG_AMT).
REQ-004 SHALL have parameter DATA_W, default 32: register data width.
REQ-005 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads zero, and writes and reservations to it are ignored.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- src  in  NUM_READ x AW  read addresses.
- dataout  out  NUM_READ x DATA_W  read data.
- rd_busy  out  NUM_READ  1 = value at src[i] still pending.
- dst  in  NUM_WRITE x AW  write addresses.
- datain  in  NUM_WRITE x DATA_W  write data.
- wr_en  in  NUM_WRITE  per-port write enable.
- rsv_en  in  1  reserve (mark pending) register rsv_adrs.
- rsv_adrs  in  AW  register to reserve.
- busy  out  REG_AMT  scoreboard vector, one bit per register.

Function
REQ-007 SHALL update register dst[j] to datain[j] on the rising edge when wr_en[j]=1; registers not written hold their value.
REQ-008 SHALL resolve two or more enabled ports writing the same dst so that the highest port index wins.
REQ-009 SHALL drive dataout[i] combinationally.
- If an enabled write targets src[i] in the same cycle, output that write's datain (highest index wins).
- Otherwise output the stored value of src[i].
REQ-010 SHALL force dataout[i]=0 and rd_busy[i]=0 when ZERO_REG=1 and src[i]=0, regardless of writes.
REQ-011 SHALL set busy[rsv_adrs] on the next edge when rsv_en=1.
REQ-012 SHALL clear busy[dst[j]] on the next edge when wr_en[j]=1.
REQ-013 SHALL leave busy set when a reserve and a write hit the same register in one cycle, because the new reservation wins.
REQ-014 SHALL drive rd_busy[i] = busy[src[i]] AND NOT(any enabled write to src[i] this cycle), unless src[i] was also reserved this cycle.
REQ-015 SHALL ignore out-of-range addresses (address >= REG_AMT) for writes and reservations; reads of them SHALL return 0 with rd_busy=0.
REQ-016 SHALL produce no X on any output after reset for any legal input.

Reset
REQ-017 SHALL set, while reset=1 at a rising edge, all registers to 0 and all busy bits to 0; writes and reservations in that cycle are discarded.
REQ-018 SHALL drive, during reset and the cycle after, dataout from the combinational path per REQ-009; the bypass stays active in the reset cycle.

Structure
REQ-019 SHALL take t_data, t_RFadrs, REG_AMT, READ_PORTS and WRITE_PORTS from the shared package; the parameter defaults equal the package values.
REQ-020 SHALL place the scoreboard in one sub-module, rf_scoreboard (busy vector, reserve/clear logic); storage and the bypass muxes stay in rf_bypass.

Verification
REQ-021 Reset, then read all registers -> dataout=0 and busy=0 for every register.
REQ-022 Port0 writes r3=0x11 and port1 writes r3=0x22 in the same cycle, with src0=r3 that cycle -> dataout0=0x22 that cycle; r3=0x22 afterwards.
REQ-023 Write r0=0xFFFF_FFFF with ZERO_REG=1 -> dataout for src=r0 is 0 in that cycle and all later cycles.
REQ-024 rsv_en on r5, next cycle src0=r5 -> rd_busy0=1; then a write of r5=0x5A -> rd_busy0=0 and dataout0=0x5A in the write cycle; busy[5]=0 next cycle.
REQ-025 Reserve r7 and write r7=0x1 in the same cycle -> busy[7]=1 next cycle and r7 reads 0x1.
REQ-026 Assert reset mid-stream with busy[2]=1 and r2=0x9 -> r2=0 and busy=0 after the edge, even though a write to r4 was presented that cycle.
